// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered datapath bus multiplexer.
//
// Picks one of N_SRC source words using the one-hot out-enable strobes from the
// control unit. The chosen word is driven onto the bus from a register one cycle
// after the strobe. When two or more strobes are high in the same cycle, the
// lowest index wins and the cycle is counted as a conflict.
//
// Ports:
//   clock           rising-edge clock
//   clear           asynchronous active-high reset
//   src_data        packed source words; source i at [i*WIDTH +: WIDTH]
//   src_out         out-enable strobes, bit i requests the bus for source i
//   err_clr         synchronous clear of the conflict sticky flag and counter
//   bus_out         registered bus word
//   bus_valid       bus_out was loaded from a source on the last edge
//   bus_sel         index of the source latched into bus_out
//   conflict        one-cycle pulse: the last sampled cycle had >= 2 enables
//   conflict_sticky set on any conflict, held until err_clr or clear
//   conflict_count  saturating count of conflict cycles
module bus_mux_reg #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N_SRC     = 24,
   parameter int unsigned HOLD_LAST = 1,
   parameter int unsigned CNT_W     = 8,
   localparam int unsigned SEL_W    = $clog2(N_SRC)
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic [N_SRC*WIDTH-1:0] src_data,
   input  logic [N_SRC-1:0]       src_out,
   input  logic                   err_clr,
   output logic [WIDTH-1:0]       bus_out,
   output logic                   bus_valid,
   output logic [SEL_W-1:0]       bus_sel,
   output logic                   conflict,
   output logic                   conflict_sticky,
   output logic [CNT_W-1:0]       conflict_count
);

   logic [WIDTH-1:0] bus_q, bus_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             conflict_q, conflict_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [SEL_W-1:0] low_idx;
   logic [WIDTH-1:0] low_data;
   logic             any_en;
   logic             multi_en;
   logic [CNT_W-1:0] count_base;

   // Priority encode and mux in one pass: scanning from the top down leaves the
   // lowest enabled index (and its word) as the final assignment.
   always_comb begin
      low_idx  = '0;
      low_data = '0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (src_out[i]) begin
            low_idx  = SEL_W'(i);
            low_data = src_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Clearing the lowest set bit leaves something behind only if >= 2 bits were set.
   assign any_en   = |src_out;
   assign multi_en = |(src_out & (src_out - N_SRC'(1)));

   always_comb begin
      bus_d      = bus_q;
      sel_d      = sel_q;
      valid_d    = 1'b0;
      conflict_d = multi_en;

      if (any_en) begin
         bus_d   = low_data;
         sel_d   = low_idx;
         valid_d = 1'b1;
      end else if (HOLD_LAST == 0) begin
         bus_d = '0;
      end

      // A clear in the same cycle as a conflict applies first, so the new event
      // is recorded on top of the cleared state.
      count_base = err_clr ? '0 : count_q;
      count_d    = count_base;
      if (multi_en && (count_base != '1)) begin
         count_d = count_base + CNT_W'(1);
      end
      sticky_d = multi_en | (sticky_q & ~err_clr);
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         bus_q      <= '0;
         valid_q    <= 1'b0;
         sel_q      <= '0;
         conflict_q <= 1'b0;
         sticky_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         bus_q      <= bus_d;
         valid_q    <= valid_d;
         sel_q      <= sel_d;
         conflict_q <= conflict_d;
         sticky_q   <= sticky_d;
         count_q    <= count_d;
      end
   end

   assign bus_out         = bus_q;
   assign bus_valid       = valid_q;
   assign bus_sel         = sel_q;
   assign conflict        = conflict_q;
   assign conflict_sticky = sticky_q;
   assign conflict_count  = count_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// tb_bus_mux_reg: self-checking bench for bus_mux_reg.
// Two instances share all inputs: one holds the bus on idle cycles, the other
// zeroes it. A behavioural model predicts every output each cycle.
module tb_bus_mux_reg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned N_SRC = 24;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned SEL_W = $clog2(N_SRC);
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic                   clock;
   logic                   clear;
   logic [N_SRC*WIDTH-1:0] src_data;
   logic [N_SRC-1:0]       src_out;
   logic                   err_clr;

   logic [WIDTH-1:0] bus_out, bus_out0;
   logic             bus_valid, bus_valid0;
   logic [SEL_W-1:0] bus_sel, bus_sel0;
   logic             conflict, conflict0;
   logic             conflict_sticky, conflict_sticky0;
   logic [CNT_W-1:0] conflict_count, conflict_count0;

   int checks   = 0;
   int failures = 0;
   bit started  = 0;

   bus_mux_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .HOLD_LAST(1), .CNT_W(CNT_W)) dut (
      .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
      .err_clr(err_clr), .bus_out(bus_out), .bus_valid(bus_valid), .bus_sel(bus_sel),
      .conflict(conflict), .conflict_sticky(conflict_sticky),
      .conflict_count(conflict_count)
   );

   bus_mux_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .HOLD_LAST(0), .CNT_W(CNT_W)) dut0 (
      .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
      .err_clr(err_clr), .bus_out(bus_out0), .bus_valid(bus_valid0), .bus_sel(bus_sel0),
      .conflict(conflict0), .conflict_sticky(conflict_sticky0),
      .conflict_count(conflict_count0)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [WIDTH-1:0] m_bus, m_bus0;
   logic             m_valid;
   int               m_sel;
   logic             m_conf;
   logic             m_sticky;
   int               m_count;

   function automatic int lowest(input logic [N_SRC-1:0] en);
      for (int i = 0; i < int'(N_SRC); i++) if (en[i]) return i;
      return -1;
   endfunction

   function automatic int next_count(input int cur, input bit clr, input int pc);
      int c;
      c = clr ? 0 : cur;
      if (pc >= 2 && c < CMAX) c = c + 1;
      return c;
   endfunction

   always @(posedge clock or posedge clear) begin
      if (clear) begin
         m_bus    <= '0;
         m_bus0   <= '0;
         m_valid  <= 1'b0;
         m_sel    <= 0;
         m_conf   <= 1'b0;
         m_sticky <= 1'b0;
         m_count  <= 0;
      end else begin
         if ($countones(src_out) == 0) begin
            m_bus0  <= '0;
            m_valid <= 1'b0;
         end else begin
            m_bus   <= src_data[lowest(src_out)*WIDTH +: WIDTH];
            m_bus0  <= src_data[lowest(src_out)*WIDTH +: WIDTH];
            m_sel   <= lowest(src_out);
            m_valid <= 1'b1;
         end
         m_conf   <= ($countones(src_out) >= 2);
         m_sticky <= ($countones(src_out) >= 2) || (m_sticky && !err_clr);
         m_count  <= next_count(m_count, err_clr, $countones(src_out));
      end
   end

   always @(negedge clock) begin
      if (started && !clear) begin
         check("bus_out", 64'(bus_out), 64'(m_bus));
         check("bus_out_h0", 64'(bus_out0), 64'(m_bus0));
         check("bus_valid", 64'(bus_valid), 64'(m_valid));
         check("bus_sel", 64'(bus_sel), 64'(m_sel));
         check("conflict", 64'(conflict), 64'(m_conf));
         check("sticky", 64'(conflict_sticky), 64'(m_sticky));
         check("count", 64'(conflict_count), 64'(m_count));
         check("count_h0", 64'(conflict_count0), 64'(m_count));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic [N_SRC-1:0] en, input logic ec);
      src_out = en;
      err_clr = ec;
      @(negedge clock);
   endtask

   task automatic set_word(input int idx, input logic [WIDTH-1:0] val);
      src_data[idx*WIDTH +: WIDTH] = val;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bus"}, 64'(bus_out), 64'h0);
      check({tag, "_bus0"}, 64'(bus_out0), 64'h0);
      check({tag, "_valid"}, 64'(bus_valid), 64'h0);
      check({tag, "_sel"}, 64'(bus_sel), 64'h0);
      check({tag, "_conf"}, 64'(conflict), 64'h0);
      check({tag, "_sticky"}, 64'(conflict_sticky), 64'h0);
      check({tag, "_count"}, 64'(conflict_count), 64'h0);
   endtask

   logic [N_SRC-1:0] two_en;
   logic [N_SRC-1:0] rnd_en;

   initial begin
      clear    = 1'b1;
      src_data = '0;
      src_out  = '0;
      err_clr  = 1'b0;
      #1;
      check_all_zero("rst0");
      @(negedge clock);
      @(negedge clock);
      clear   = 1'b0;
      started = 1;

      // Single drivers
      set_word(20, 32'h0000_0104);
      cyc(N_SRC'(1) << 20, 1'b0);
      check("pc_bus", 64'(bus_out), 64'h104);
      check("pc_sel", 64'(bus_sel), 64'd20);
      check("pc_valid", 64'(bus_valid), 64'd1);
      check("pc_conf", 64'(conflict), 64'd0);
      set_word(3, 32'h7);
      cyc(N_SRC'(1) << 3, 1'b0);
      check("s3_bus", 64'(bus_out), 64'h7);
      check("s3_sel", 64'(bus_sel), 64'd3);

      // Idle hold vs zero
      set_word(0, 32'h55AA_55AA);
      cyc(N_SRC'(1), 1'b0);
      for (int k = 0; k < 3; k++) cyc('0, 1'b0);
      check("hold_bus", 64'(bus_out), 64'h55AA_55AA);
      check("hold_valid", 64'(bus_valid), 64'd0);
      check("hold_sel", 64'(bus_sel), 64'd0);
      check("zero_bus", 64'(bus_out0), 64'h0);

      // Conflict: lowest index wins
      set_word(5, 32'h11);
      set_word(17, 32'h22);
      two_en = (N_SRC'(1) << 5) | (N_SRC'(1) << 17);
      cyc(two_en, 1'b0);
      check("cf_bus", 64'(bus_out), 64'h11);
      check("cf_sel", 64'(bus_sel), 64'd5);
      check("cf_conf", 64'(conflict), 64'd1);
      check("cf_sticky", 64'(conflict_sticky), 64'd1);
      check("cf_count", 64'(conflict_count), 64'd1);
      cyc('0, 1'b0);
      check("cf_pulse_end", 64'(conflict), 64'd0);
      check("cf_sticky_held", 64'(conflict_sticky), 64'd1);

      // Saturation, then clear on an idle cycle
      for (int k = 0; k < 300; k++) cyc(two_en, 1'b0);
      check("sat_count", 64'(conflict_count), 64'd255);
      cyc('0, 1'b1);
      check("clr_sticky", 64'(conflict_sticky), 64'd0);
      check("clr_count", 64'(conflict_count), 64'd0);
      check("clr_bus", 64'(bus_out), 64'h11);

      // Clear coinciding with a conflict
      for (int k = 0; k < 40; k++) cyc(two_en, 1'b0);
      check("c40_count", 64'(conflict_count), 64'd40);
      cyc(two_en, 1'b1);
      check("sim_count", 64'(conflict_count), 64'd1);
      check("sim_sticky", 64'(conflict_sticky), 64'd1);

      // Randomized traffic
      for (int k = 0; k < 800; k++) begin
         for (int s = 0; s < int'(N_SRC); s++) set_word(s, $urandom);
         case ($urandom_range(0, 3))
            0: rnd_en = '0;
            1: rnd_en = N_SRC'(1) << $urandom_range(0, N_SRC - 1);
            2: rnd_en = N_SRC'($urandom) & N_SRC'($urandom);
            default: rnd_en = N_SRC'($urandom);
         endcase
         cyc(rnd_en, ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset mid-cycle
      set_word(7, 32'hDEAD_BEEF);
      cyc(N_SRC'(1) << 7, 1'b0);
      check("db_bus", 64'(bus_out), 64'hDEAD_BEEF);
      #2 clear = 1'b1;
      #1;
      check_all_zero("rst1");
      cyc(two_en, 1'b0);
      clear = 1'b0;
      cyc('0, 1'b0);
      cyc('0, 1'b0);
      check("post_bus", 64'(bus_out), 64'h0);
      check("post_valid", 64'(bus_valid), 64'h0);
      check("post_count", 64'(conflict_count), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
